// File: rtl/rw_pulse_timer.sv
// ============================================================================
// Module   : rw_pulse_timer
// Purpose  : Wordline / sense-amp pulse sequencer for one SRAM access, timed
//            from an external up-counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rw_pulse_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] t_wl_on,
  input  logic [WIDTH-1:0] t_sae,
  input  logic [WIDTH-1:0] t_end,
  input  logic [WIDTH-1:0] value,
  output logic             cnt_en,
  output logic             cnt_rst,
  output logic             wl_en,
  output logic             sae,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             wl_en_q, wl_en_d;
  logic             sae_q, sae_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] t_wl_on_q, t_wl_on_d;
  logic [WIDTH-1:0] t_sae_q, t_sae_d;
  logic [WIDTH-1:0] t_end_q, t_end_d;

  logic             cfg_ok;

  assign cfg_ok = (t_wl_on < t_sae) && (t_sae < t_end);

  always_comb begin
    state_d   = state_q;
    wl_en_d   = 1'b0;
    sae_d     = 1'b0;
    cfg_err_d = 1'b0;
    t_wl_on_d = t_wl_on_q;
    t_sae_d   = t_sae_q;
    t_end_d   = t_end_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            t_wl_on_d = t_wl_on;
            t_sae_d   = t_sae;
            t_end_d   = t_end;
            state_d   = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Pulse windows use only the latched thresholds, so the live inputs
        // may change freely while an access is in flight.
        wl_en_d = (value >= t_wl_on_q) && (value < t_sae_q);
        sae_d   = (value >= t_sae_q) && (value < t_end_q);
        if (value == t_end_q) begin
          wl_en_d = 1'b0;
          sae_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wl_en_q   <= 1'b0;
      sae_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      t_wl_on_q <= '0;
      t_sae_q   <= '0;
      t_end_q   <= '0;
    end else begin
      state_q   <= state_d;
      wl_en_q   <= wl_en_d;
      sae_q     <= sae_d;
      cfg_err_q <= cfg_err_d;
      t_wl_on_q <= t_wl_on_d;
      t_sae_q   <= t_sae_d;
      t_end_q   <= t_end_d;
    end
  end

  // Counter is held in reset whenever no access runs, so it reads 0 on the
  // first RUN cycle.
  assign cnt_en  = (state_q == RUN);
  assign cnt_rst = rst | (state_q != RUN);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign wl_en   = wl_en_q;
  assign sae     = sae_q;
  assign cfg_err = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rw_pulse_timer.sv
// ============================================================================
// Module   : tb_rw_pulse_timer
// Purpose  : Directed scoreboard bench for rw_pulse_timer with counter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rw_pulse_timer;

  localparam int WIDTH = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] t_wl_on, t_sae, t_end;
  logic [WIDTH-1:0] value = '0;
  logic             cnt_en, cnt_rst, wl_en, sae, busy, done, cfg_err;

  always #5 clk = ~clk;

  rw_pulse_timer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .t_wl_on(t_wl_on),
    .t_sae  (t_sae),
    .t_end  (t_end),
    .value  (value),
    .cnt_en (cnt_en),
    .cnt_rst(cnt_rst),
    .wl_en  (wl_en),
    .sae    (sae),
    .busy   (busy),
    .done   (done),
    .cfg_err(cfg_err)
  );

  // External counter
  always @(posedge clk) begin
    if (cnt_rst)     value <= '0;
    else if (cnt_en) value <= value + 1'b1;
  end

  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Access model: n counts edges since the accepting edge.
  bit m_act = 1'b0;
  int m_n   = 0;
  int m_wl  = 0;
  int m_sa  = 0;
  int m_end = 0;

  // Vector order: busy, done, wl_en, sae, cfg_err, cnt_en, cnt_rst
  task automatic step(input string tag);
    exp_t       it;
    exp_t       got;
    logic [6:0] obs;
    bit         ce, b, d, w, s;
    ce = 1'b0;
    if (rst) begin
      m_act = 1'b0;
    end else if (m_act) begin
      m_n++;
      if (m_n == m_end + 2) m_act = 1'b0;
    end else if (start) begin
      if ((t_wl_on < t_sae) && (t_sae < t_end)) begin
        m_act = 1'b1;
        m_n   = 0;
        m_wl  = int'(t_wl_on);
        m_sa  = int'(t_sae);
        m_end = int'(t_end);
      end else begin
        ce = 1'b1;
      end
    end
    b = m_act && (m_n <= m_end);
    d = m_act && (m_n == m_end + 1);
    w = m_act && (m_n >= m_wl + 1) && (m_n <= m_sa);
    s = m_act && (m_n >= m_sa + 1) && (m_n <= m_end);
    it.v   = {b, d, w, s, ce, b, (rst | ~b)};
    it.tag = tag;
    sb.push_back(it);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    obs = {busy, done, wl_en, sae, cfg_err, cnt_en, cnt_rst};
    checks++;
    assert (obs === got.v) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b (busy,done,wl,sae,cfg_err,cnt_en,cnt_rst)",
             got.tag, obs, got.v);
    end
  endtask

  task automatic check_value_zero(input string tag);
    checks++;
    assert (value === '0) else begin
      failures++;
      $error("FAIL %s value=%0d exp=0", tag, value);
    end
  endtask

  task automatic set_thr(input int a, input int b, input int c);
    t_wl_on = WIDTH'(a);
    t_sae   = WIDTH'(b);
    t_end   = WIDTH'(c);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_thr(2, 5, 8);
    repeat (2) step("reset");
    rst = 1'b0;
    repeat (2) step("idle");

    // Basic access
    start = 1'b1;
    step("basic_start");
    start = 1'b0;
    repeat (12) step("basic");
    check_value_zero("basic_value");

    // Invalid configurations
    set_thr(5, 5, 8);
    start = 1'b1; step("bad_5_5_8");
    start = 1'b0; repeat (2) step("bad_5_5_8_after");
    set_thr(6, 3, 8);
    start = 1'b1; step("bad_6_3_8");
    start = 1'b0; repeat (2) step("bad_6_3_8_after");
    set_thr(2, 8, 8);
    start = 1'b1; step("bad_2_8_8");
    start = 1'b0; repeat (2) step("bad_2_8_8_after");

    // Threshold change while running
    set_thr(2, 5, 8);
    start = 1'b1;
    step("midchg_start");
    start = 1'b0;
    set_thr(0, 1, 2);
    repeat (12) step("midchg");
    set_thr(2, 5, 8);

    // Start held high: back-to-back accesses
    start = 1'b1;
    repeat (25) step("b2b");
    start = 1'b0;
    repeat (3) step("b2b_tail");

    // Reset while wordline is on
    start = 1'b1;
    step("rstmid_start");
    start = 1'b0;
    repeat (3) step("rstmid_run");
    rst = 1'b1;
    step("rstmid_reset");
    rst = 1'b0;
    step("rstmid_idle");
    check_value_zero("rstmid_value");
    start = 1'b1;
    step("rstmid_fresh_start");
    start = 1'b0;
    repeat (12) step("rstmid_fresh");

    // Extreme thresholds, full counter range without wrap
    set_thr(0, 1, 4095);
    start = 1'b1;
    step("edge_start");
    start = 1'b0;
    repeat (4100) step("edge");
    check_value_zero("edge_value");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
